// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path.
//   - uart_state_e    : receiver FSM states (3-bit encoding)
//   - FRAME_BITS      : start + 8 data + parity + stop
//   - MAX_DATA_BITS   : widest data word the parity helper accepts
//   - parity_mismatch : parity check on a zero-extended data word
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int FRAME_BITS    = 11;
  localparam int MAX_DATA_BITS = 16;

  // Zero-extension leaves the XOR reduction unchanged, so one helper
  // serves every DATA_BITS up to MAX_DATA_BITS.
  function automatic logic parity_mismatch(
    input logic [MAX_DATA_BITS-1:0] data,
    input logic                     par_bit,
    input logic                     odd
  );
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for the asynchronous serial line. Both flops
//   reset to 1 (line idle) so no false start edge appears after reset.
//   Ports:
//     baud_clk  in  sampling clock
//     reset     in  synchronous, active-high
//     rx_in     in  asynchronous serial line
//     rx_s      out synchronised line (2 cycles latency)
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic baud_clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s
);

  logic meta_q;

  always_ff @(posedge baud_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two stages into one.
    if (reset) begin
      meta_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      meta_q <= rx_in;
      rx_s   <= meta_q;
    end
  end

endmodule : uart_rx_sync

// File: rtl/uart_sipo_rx.sv
// ---------------------------------------------------------------------------
// uart_sipo_rx
//   UART receiver, serial-in/parallel-out. Frame: start(0), DATA_BITS data
//   bits LSB first, parity, stop(1). The line is oversampled OVERSAMPLE
//   times per bit; the start bit is confirmed at its mid-point and every
//   following bit is sampled one bit period later.
//
//   Build option: UART_RX_MAJORITY_EN
//     defined   -> each bit decision is a 2-of-3 vote over three
//                  consecutive rx_s samples, rejecting 1-cycle glitches
//     undefined -> single rx_s sample at the decision tick
//     Decision ticks, and hence valid timing, are identical in both builds.
//
//   Ports:
//     baud_clk    in   sole clock, OVERSAMPLE x bit rate
//     reset       in   synchronous, active-high
//     rx_in       in   asynchronous serial line, idle high
//     data_out    out  last received word
//     valid       out  1-cycle pulse when data_out / flags update
//     parity_err  out  parity mismatch on last frame
//     frame_err   out  stop bit sampled low on last frame
//     active_flag out  high from confirmed start to the stop sample
// ---------------------------------------------------------------------------
module uart_sipo_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,  // even, >= 8
  parameter int DATA_BITS  = 8,   // 1..MAX_DATA_BITS
  parameter int PARITY_ODD = 0    // 0: even parity, 1: odd parity
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 active_flag
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_d1_q;     // rx_s one cycle ago; edge detect + vote
  logic                 sample_bit;  // bit value used at a decision tick
  uart_state_e          state_q;
  logic [TW-1:0]        tcnt_q;
  logic [BW-1:0]        bcnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;

  uart_rx_sync u_sync (
    .baud_clk (baud_clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_s     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2_q;

  always_ff @(posedge baud_clk) begin
    if (reset) rx_d2_q <= 1'b1;
    else       rx_d2_q <= rx_d1_q;
  end

  // Vote over the window ending at the decision tick; the window centre is
  // one cycle before the tick, so a single-cycle glitch there is outvoted.
  assign sample_bit = (rx_s & rx_d1_q) | (rx_s & rx_d2_q) | (rx_d1_q & rx_d2_q);
`else
  assign sample_bit = rx_s;
`endif

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      rx_d1_q     <= 1'b1;
      data_out    <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      rx_d1_q <= rx_s;
      valid   <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // Only a 1->0 transition starts a frame; a held-low line (break)
          // never re-triggers.
          if (rx_d1_q && !rx_s) begin
            state_q <= START;
            tcnt_q  <= '0;
          end
        end

        START: begin
          if (tcnt_q == T_MID) begin
            tcnt_q <= '0;
            if (sample_bit) begin
              state_q <= IDLE;  // glitch: outputs untouched
            end else begin
              state_q     <= DATA;
              bcnt_q      <= '0;
              active_flag <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_q <= '0;
            // LSB arrives first, so shift in from the top.
            if (DATA_BITS > 1) shreg_q <= {sample_bit, shreg_q[DATA_BITS-1:1]};
            else               shreg_q <= sample_bit;
            if (bcnt_q == B_LAST) state_q <= PARITY;
            else                  bcnt_q  <= bcnt_q + BW'(1);
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        PARITY: begin
          if (tcnt_q == T_LAST) begin
            tcnt_q  <= '0;
            par_q   <= sample_bit;
            state_q <= STOP;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        STOP: begin
          // Outputs register on the stop-sample edge and appear the next
          // cycle. Returning to IDLE here leaves the second half of the stop
          // bit free to catch a back-to-back start edge.
          if (tcnt_q == T_LAST) begin
            tcnt_q      <= '0;
            data_out    <= shreg_q;
            valid       <= 1'b1;
            frame_err   <= ~sample_bit;
            parity_err  <= parity_mismatch(MAX_DATA_BITS'(shreg_q), par_q,
                                           PARITY_ODD != 0);
            active_flag <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : uart_sipo_rx

// File: tb/tb_uart_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_sipo_rx
//   Directed plus random frames for uart_sipo_rx at OVERSAMPLE=16, even
//   parity. Expected values come from the frame-level rules: data is the
//   byte sent, parity_err is set when the count of ones over data and parity
//   bit is odd, frame_err is the inverse of the stop bit.
// ---------------------------------------------------------------------------
module tb_uart_sipo_rx;
  import uart_pkg::FRAME_BITS;

  localparam int OS = 16;

  typedef logic wave_t[$];

  logic       baud_clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       active_flag;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         start_cyc = 0;
  int         valid_cyc = 0;
  bit         active_seen = 1'b0;
  logic [9:0] obs_q[$];   // {data_out, parity_err, frame_err} per valid pulse

  uart_sipo_rx #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .PARITY_ODD (0)
  ) dut (
    .baud_clk    (baud_clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .valid       (valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .active_flag (active_flag)
  );

  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Outputs are observed on the falling edge, away from the active edge.
  always @(negedge baud_clk) begin
    if (valid === 1'b1) begin
      obs_q.push_back({data_out, parity_err, frame_err});
      valid_cyc = cyc;
    end
    if (active_flag === 1'b1) active_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wave_t make_frame(input logic [7:0] d, input logic par,
                                       input logic stop);
    wave_t      w;
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int b = 0; b < FRAME_BITS; b++)
      for (int k = 0; k < OS; k++) w.push_back(bits[b]);
    return w;
  endfunction

  task automatic drive_wave(input wave_t w);
    foreach (w[i]) begin
      if (i == 0) start_cyc = cyc;
      rx_in = w[i];
      @(negedge baud_clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge baud_clk);
  endtask

  // Pops one observed frame and compares it with the frame-level model.
  task automatic check_frame(input string tag, input logic [7:0] d,
                             input logic par, input logic stop);
    logic [9:0] o;
    logic       exp_pe;
    logic       exp_fe;
    if (obs_q.size() == 0) return;  // the count check already reported it
    exp_pe = (($countones(d) + int'(par)) % 2) != 0;
    exp_fe = ~stop;
    o = obs_q.pop_front();
    check({tag, " data"},       32'(o[9:2]), 32'(d));
    check({tag, " parity_err"}, 32'(o[1]),   32'(exp_pe));
    check({tag, " frame_err"},  32'(o[0]),   32'(exp_fe));
  endtask

  initial begin
    wave_t      w;
    logic [7:0] rd;
    logic       rp;
    logic       rs;
    int         lat;

    // Reset state
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge baud_clk);
    check("reset data_out",    32'(data_out),    32'h0);
    check("reset valid",       32'(valid),       32'h0);
    check("reset parity_err",  32'(parity_err),  32'h0);
    check("reset frame_err",   32'(frame_err),   32'h0);
    check("reset active_flag", 32'(active_flag), 32'h0);
    reset = 1'b0;
    idle(32);

    // Clean frame 0xA5, correct even parity
    active_seen = 1'b0;
    drive_wave(make_frame(8'hA5, 1'b0, 1'b1));
    idle(32);
    check("a5 count", 32'(obs_q.size()), 32'd1);
    check("a5 active seen", 32'(active_seen), 32'd1);
    lat = valid_cyc - start_cyc;
    check("a5 latency window", 32'(lat >= 150 && lat <= 180), 32'd1);
    check("a5 active low after", 32'(active_flag), 32'd0);
    check_frame("a5", 8'hA5, 1'b0, 1'b1);

    // Parity error: 0x01 needs parity 1, sent 0
    drive_wave(make_frame(8'h01, 1'b0, 1'b1));
    idle(32);
    check("par count", 32'(obs_q.size()), 32'd1);
    check_frame("par", 8'h01, 1'b0, 1'b1);

    // Frame error followed by a long break: exactly one pulse
    drive_wave(make_frame(8'h3C, 1'b0, 1'b0));
    rx_in = 1'b0;
    repeat (40 * OS) @(negedge baud_clk);
    idle(48);
    check("break count", 32'(obs_q.size()), 32'd1);
    check_frame("break", 8'h3C, 1'b0, 1'b0);

    // Short low glitch on an idle line: rejected start
    active_seen = 1'b0;
    rx_in = 1'b0;
    repeat (4) @(negedge baud_clk);
    idle(48);
    check("glitch count", 32'(obs_q.size()), 32'd0);
    check("glitch active", 32'(active_seen), 32'd0);
    check("glitch flags held", 32'({parity_err, frame_err}), 32'b01);

    // Back-to-back frames with no idle gap
    drive_wave(make_frame(8'h00, 1'b0, 1'b1));
    drive_wave(make_frame(8'hFF, 1'b0, 1'b1));
    idle(32);
    check("b2b count", 32'(obs_q.size()), 32'd2);
    check_frame("b2b first", 8'h00, 1'b0, 1'b1);
    check_frame("b2b second", 8'hFF, 1'b0, 1'b1);

    // Reset during data bit 4 of 0x55, then a clean 0xAA
    w = make_frame(8'h55, 1'b0, 1'b1);
    for (int i = 0; i < 5 * OS; i++) begin
      rx_in = w[i];
      @(negedge baud_clk);
    end
    rx_in = w[5 * OS];
    reset = 1'b1;
    repeat (3) @(negedge baud_clk);
    reset = 1'b0;
    check("midrst active", 32'(active_flag), 32'd0);
    check("midrst data_out", 32'(data_out), 32'h0);
    idle(3 * OS);
    check("midrst count", 32'(obs_q.size()), 32'd0);
    drive_wave(make_frame(8'hAA, 1'b0, 1'b1));
    idle(32);
    check("aa count", 32'(obs_q.size()), 32'd1);
    check_frame("aa", 8'hAA, 1'b0, 1'b1);

    // Random frames: random data, random parity bit, mostly-good stop
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      drive_wave(make_frame(rd, rp, rs));
      idle(2 * OS);
      check($sformatf("rand%0d count", n), 32'(obs_q.size()), 32'd1);
      check_frame($sformatf("rand%0d", n), rd, rp, rs);
    end

`ifdef UART_RX_MAJORITY_EN
    // One-cycle high glitch at the centre of data bit 2 of 0x00
    w = make_frame(8'h00, 1'b0, 1'b1);
    w[OS + 2 * OS + OS / 2 - 1] = 1'b1;
    drive_wave(w);
    idle(32);
    check("maj count", 32'(obs_q.size()), 32'd1);
    check_frame("maj", 8'h00, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_sipo_rx
